ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one asynchronous `ram` instance between two synchronous requesters: port 0 (CPU bus glue) and port 1 (DMA/video fetch).
- Each ram access is sequenced as setup, enable strobe, then hold, so address and data are stable around the enable pulse.
- Drives the ram's addr, bidirectional data, enable and write pins. Returns a one-cycle ack and read data to the winning requester.
- Round-robin arbitration prevents either port from starving the other.

Parameters:
- ADDR_WIDTH, 8, ram address width.
- DATA_WIDTH, 8, ram data width.
- STROBE_CYCLES, 1, cycles ram_enable is held high per access (must be >= 1).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req0 / req1  input  1  access request, level; held until the matching ack.
- addr0 / addr1  input  ADDR_WIDTH  request address; stable while req is high.
- write0 / write1  input  1  1 = write, 0 = read; stable while req is high.
- wdata0 / wdata1  input  DATA_WIDTH  write data; stable while req is high.
- ack0 / ack1  output  1  one-cycle pulse marking completion.
- rdata  output  DATA_WIDTH  read data; valid in the ack cycle of a read, held until the next read capture.
- grant  output  1  port currently being served; valid when busy = 1.
- busy  output  1  1 in any state other than IDLE.
- ram_addr  output  ADDR_WIDTH  to ram addr.
- ram_data  inout  DATA_WIDTH  to ram data; driven only during write accesses, otherwise 'bz.
- ram_enable  output  1  to ram enable.
- ram_write  output  1  to ram write.

Behaviour:
- Reset values (rst_n = 0 at a clock edge):
  - state = IDLE; ack0 = ack1 = 0; ram_enable = 0; ram_write = 0.
  - ram_data released ('bz); ram_addr = 0; rdata = 0; grant = 0; busy = 0.
  - priority pointer = 0, so port 0 wins the first tie.
- Reset mid-access aborts immediately. The enable strobe is cut, the bus is released, and no ack is issued. The requester must keep req high and is re-served after reset.
- IDLE:
  - If any req is high, pick the winner.
  - Sole requester wins. If both request, the port equal to the priority pointer wins.
  - Latch the winner's addr, write and wdata, set grant, then go to SETUP.
  - The priority pointer is set to the non-winning port at the grant.
- SETUP (1 cycle):
  - ram_addr = latched addr; ram_write = latched write; ram_enable = 0.
  - ram_data is driven with latched wdata if write, else 'bz.
- STROBE (STROBE_CYCLES cycles):
  - Same drives as SETUP, plus ram_enable = 1. A down-counter tracks the remaining cycles.
  - On the last STROBE cycle of a read, rdata captures ram_data at the clock edge.
- HOLD (1 cycle):
  - ram_enable = 0; addr, write and write-data drive are held.
  - The granted port's ack = 1.
  - Next state is IDLE.
- ram_data is released and ram_write returns to 0 on entry to IDLE.
- Latency: ack is asserted STROBE_CYCLES + 2 cycles after the IDLE cycle that samples req. With the default this is 3 cycles. One access takes STROBE_CYCLES + 3 cycles including IDLE.
- Back-to-back requests:
  - A req still high in the IDLE cycle after ack is a new request.
  - A requester that wants only one access must drop req in the cycle after ack.
- Simultaneous requests alternate strictly: 0, 1, 0, 1 …
- A req that goes high while busy waits. It is never lost and never preempts the access in flight.
- Latched request fields ignore input changes after the grant.

Decomposition:
- Shared package glue_pkg:
  - state encoding localparams: IDLE, SETUP, STROBE, HOLD.
  - port index constants PORT_CPU = 0 and PORT_DMA = 1.
- One natural sub-module: ram_rr_pick. It is purely combinational: inputs req0, req1 and pointer; outputs valid and winner. Keep it separate so it can be reused when a third requester is added.
- The sequencer FSM and strobe counter stay in ram_arbiter.

Test Plan:
- Write then read, port 0:
  - Stimulus: write 0x80 to addr 0x01, then read addr 0x01.
  - Required: ack0 arrives 3 cycles after each request is sampled; rdata = 0x80 in the read's ack cycle; ack1 never asserted.
  - Check: ram_enable is high exactly 1 cycle per access, with ram_addr stable from SETUP through HOLD.
- Simultaneous requests:
  - Stimulus: req0 (write 0x81 to 0x02) and req1 (write 0x55 to 0x03) raised in the same cycle.
  - Required: port 0 is served first, then port 1.
  - Check: subsequent reads return 0x81 and 0x55.
  - Fairness: with both reqs held high for 4 accesses, grant sequence = 0, 1, 0, 1.
- Stable-input and bus-release check:
  - Stimulus: change addr0 to 0x7F in the cycle after the grant of a write to 0x10.
  - Required: the write lands at 0x10.
  - Check: ram_data is 'bz in every IDLE cycle and throughout read accesses.
- STROBE_CYCLES = 3:
  - Stimulus: a read of a preloaded location with value 0xA5.
  - Required: ram_enable high for exactly 3 cycles; ack 5 cycles after the request is sampled; rdata = 0xA5.
- Reset mid-access:
  - Stimulus: drop rst_n during STROBE of a port 1 write.
  - Required, next cycle: ram_enable = 0, ram_data = 'bz, no ack, busy = 0.
  - Required, after rst_n is released with req1 still high: the write is re-sequenced and ack1 is seen.
- Late request while busy:
  - Stimulus: req1 rises during port 0's STROBE.
  - Required: port 1 is granted in the IDLE cycle immediately after port 0's HOLD, with no lost or duplicate ack.

Source files
------------

// File: rtl/glue_pkg.sv
// Shared definitions for the ram arbiter: sequencer state encoding and
// requester port indices.
package glue_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the ram arbiter: two request ports plus the
// shared ack/read-data/status returns.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    // Handshake: reqN is a level held (with addrN/writeN/wdataN stable) until
    // ackN pulses for one cycle; a req still high after ack is a new request.
    logic                  req0;
    logic                  req1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic                  write0;
    logic                  write1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  ack0;
    logic                  ack1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  grant;
    logic                  busy;

    modport master (
        output req0, req1, addr0, addr1, write0, write1, wdata0, wdata1,
        input  ack0, ack1, rdata, grant, busy
    );

    modport slave (
        input  req0, req1, addr0, addr1, write0, write1, wdata0, wdata1,
        output ack0, ack1, rdata, grant, busy
    );

endinterface

// File: rtl/ram_rr_pick.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the port
// named by the priority pointer.
module ram_rr_pick
    import glue_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic pointer,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = pointer;
        end else if (req1) begin
            winner = PORT_DMA;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one asynchronous ram between two requesters, sequencing each access
// as setup, enable strobe and hold so the ram pins are stable around enable.
module ram_arbiter
    import glue_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int STROBE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ram_arbiter_if.slave          bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_enable,
    output logic                  ram_write,
    output state_t                dbg_state
);

    localparam int CNT_W = $clog2(STROBE_CYCLES + 1);

    state_t                state;
    state_t                state_next;
    logic                  ptr;
    logic                  grant_q;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0]      cnt;
    logic                  pick_valid;
    logic                  pick_winner;
    logic                  last_strobe;
    logic                  drive_data;

    ram_rr_pick u_pick (
        .req0    (bus.req0),
        .req1    (bus.req1),
        .pointer (ptr),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    assign last_strobe = (cnt == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus.ack0   = 1'b0;
        bus.ack1   = 1'b0;
        case (state)
            IDLE:    if (pick_valid) state_next = SETUP;
            SETUP:   state_next = STROBE;
            STROBE:  if (last_strobe) state_next = HOLD;
            HOLD: begin
                state_next = IDLE;
                if (grant_q == PORT_DMA) bus.ack1 = 1'b1;
                else                     bus.ack0 = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured only at the grant, so requesters may change
    // their inputs freely once the access is in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= PORT_CPU;
            grant_q   <= PORT_CPU;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q   <= pick_winner;
                        ptr       <= ~pick_winner;
                        lat_addr  <= (pick_winner == PORT_DMA) ? bus.addr1  : bus.addr0;
                        lat_write <= (pick_winner == PORT_DMA) ? bus.write1 : bus.write0;
                        lat_wdata <= (pick_winner == PORT_DMA) ? bus.wdata1 : bus.wdata0;
                    end
                end
                SETUP:  cnt <= CNT_W'(STROBE_CYCLES);
                STROBE: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_strobe && !lat_write) rdata_q <= ram_data;
                end
                default: ;
            endcase
        end
    end

    assign drive_data = (state != IDLE) && lat_write;
    assign ram_data   = drive_data ? lat_wdata : {DATA_WIDTH{1'bz}};
    assign ram_addr   = lat_addr;
    assign ram_enable = (state == STROBE);
    assign ram_write  = drive_data;
    assign bus.rdata  = rdata_q;
    assign bus.grant  = grant_q;
    assign bus.busy   = (state != IDLE);
    assign dbg_state  = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two instances (strobe of 1 and 3 cycles),
// behavioural ram models and a queue-based scoreboard checked on every ack.
module tb_ram_arbiter;
  import glue_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  tri1 [DW-1:0] ram_data_a;
  tri1 [DW-1:0] ram_data_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic ram_enable_a, ram_enable_b, ram_write_a, ram_write_b;
  state_t dbg_a, dbg_b;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .ram_addr(ram_addr_a), .ram_data(ram_data_a),
    .ram_enable(ram_enable_a), .ram_write(ram_write_a), .dbg_state(dbg_a)
  );

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STROBE_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .ram_addr(ram_addr_b), .ram_data(ram_data_b),
    .ram_enable(ram_enable_b), .ram_write(ram_write_b), .dbg_state(dbg_b)
  );

  // behavioural asynchronous rams
  logic [DW-1:0] mem_a [256];
  logic [DW-1:0] mem_b [256];
  assign ram_data_a = (ram_enable_a && !ram_write_a) ? mem_a[ram_addr_a] : {DW{1'bz}};
  assign ram_data_b = (ram_enable_b && !ram_write_b) ? mem_b[ram_addr_b] : {DW{1'bz}};
  always @(posedge clk) if (ram_enable_a && ram_write_a) mem_a[ram_addr_a] <= ram_data_a;
  always @(posedge clk) if (ram_enable_b && ram_write_b) mem_b[ram_addr_b] <= ram_data_b;

  // scoreboard entries: {port, is_read, addr, data}
  logic [17:0] exp_q[$];
  logic [17:0] exp_qb[$];

  function automatic logic [17:0] ent(logic p, logic r, logic [7:0] a, logic [7:0] d);
    return {p, r, a, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input logic b, input logic p, input logic r, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] d);
    case ({b, p})
      2'b00: begin bus_a.req0 = r; bus_a.addr0 = a; bus_a.write0 = w; bus_a.wdata0 = d; end
      2'b01: begin bus_a.req1 = r; bus_a.addr1 = a; bus_a.write1 = w; bus_a.wdata1 = d; end
      2'b10: begin bus_b.req0 = r; bus_b.addr0 = a; bus_b.write0 = w; bus_b.wdata0 = d; end
      default: begin bus_b.req1 = r; bus_b.addr1 = a; bus_b.write1 = w; bus_b.wdata1 = d; end
    endcase
  endtask

  function automatic logic get_ack(input logic b, input logic p);
    case ({b, p})
      2'b00:   return bus_a.ack0;
      2'b01:   return bus_a.ack1;
      2'b10:   return bus_b.ack0;
      default: return bus_b.ack1;
    endcase
  endfunction

  // Raises req at a negedge, waits for ack, drops req and returns at the
  // negedge of the following (IDLE) cycle. exp_lat < 0 skips the latency check.
  task automatic drive(input logic b, input logic p, input logic [AW-1:0] a, input logic w,
                       input logic [DW-1:0] d, input int exp_lat, input bit poke_addr);
    int n = 0;
    bit got = 0;
    set_req(b, p, 1'b1, a, w, d);
    while (!got && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1 && poke_addr) bus_a.addr0 = 8'h7F;
      got = get_ack(b, p);
    end
    set_req(b, p, 1'b0, a, w, d);
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: port %0d dut %0d got no ack within %0d cycles", p, b, n);
    end else if (exp_lat >= 0) begin
      check("ack_latency", 32'(n), 32'(exp_lat));
    end
    @(negedge clk);
  endtask

  // monitor for the STROBE_CYCLES = 1 instance
  int en_cnt_a = 0;
  bit addr_bad_a = 0;
  bit prev_busy_a = 0;
  logic [AW-1:0] addr_ref_a = '0;
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n) begin
      if (bus_a.busy && !prev_busy_a) begin
        en_cnt_a = 0;
        addr_bad_a = 0;
        addr_ref_a = ram_addr_a;
      end
      if (bus_a.busy && ram_addr_a !== addr_ref_a) addr_bad_a = 1;
      if (ram_enable_a) en_cnt_a++;
      if (!ram_enable_a && !ram_write_a) check("a_bus_release", 32'(ram_data_a), 32'hFF);
      if (bus_a.ack0 || bus_a.ack1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_ack: ack0=%0b ack1=%0b with empty queue", bus_a.ack0, bus_a.ack1);
        end else begin
          e = exp_q.pop_front();
          check("a_ack_port", 32'({bus_a.ack1, bus_a.ack0}), e[17] ? 32'h2 : 32'h1);
          check("a_ram_addr", 32'(ram_addr_a), 32'(e[15:8]));
          check("a_addr_stable", 32'(addr_bad_a), 32'h0);
          check("a_strobe_len", 32'(en_cnt_a), 32'd1);
          if (e[16]) check("a_rdata", 32'(bus_a.rdata), 32'(e[7:0]));
        end
      end
    end
    prev_busy_a = bus_a.busy;
  end

  // monitor for the STROBE_CYCLES = 3 instance
  int en_cnt_b = 0;
  bit prev_busy_b = 0;
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n) begin
      if (bus_b.busy && !prev_busy_b) en_cnt_b = 0;
      if (ram_enable_b) en_cnt_b++;
      if (bus_b.ack0 || bus_b.ack1) begin
        if (exp_qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_ack: ack0=%0b ack1=%0b with empty queue", bus_b.ack0, bus_b.ack1);
        end else begin
          e = exp_qb.pop_front();
          check("b_ack_port", 32'({bus_b.ack1, bus_b.ack0}), e[17] ? 32'h2 : 32'h1);
          check("b_strobe_len", 32'(en_cnt_b), 32'd3);
          if (e[16]) check("b_rdata", 32'(bus_b.rdata), 32'(e[7:0]));
        end
      end
    end
    prev_busy_b = bus_b.busy;
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_b[8'h05] = 8'hA5;
    set_req(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    set_req(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    set_req(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);

    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dbg_a), 32'(IDLE));
    check("rst_acks", 32'({bus_a.ack0, bus_a.ack1}), 32'h0);
    check("rst_enable_write", 32'({ram_enable_a, ram_write_a}), 32'h0);
    check("rst_ram_data", 32'(ram_data_a), 32'hFF);
    check("rst_ram_addr", 32'(ram_addr_a), 32'h0);
    check("rst_rdata", 32'(bus_a.rdata), 32'h0);
    check("rst_grant_busy", 32'({bus_a.grant, bus_a.busy}), 32'h0);
    check("rst_state_b", 32'(dbg_b), 32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // three-cycle strobe: preloaded read, ack 5 cycles after sampling
    exp_qb.push_back(ent(1'b0, 1'b1, 8'h05, 8'hA5));
    drive(1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 5, 0);

    // write then read on port 0, then port 1 reads it (pointer back to 0)
    exp_q.push_back(ent(1'b0, 1'b0, 8'h01, 8'h80));
    drive(1'b0, 1'b0, 8'h01, 1'b1, 8'h80, 3, 0);
    exp_q.push_back(ent(1'b0, 1'b1, 8'h01, 8'h80));
    drive(1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 3, 0);
    exp_q.push_back(ent(1'b1, 1'b1, 8'h01, 8'h80));
    drive(1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 3, 0);

    // simultaneous writes: port 0 first, port 1 after one full access
    exp_q.push_back(ent(1'b0, 1'b0, 8'h02, 8'h81));
    exp_q.push_back(ent(1'b1, 1'b0, 8'h03, 8'h55));
    fork
      drive(1'b0, 1'b0, 8'h02, 1'b1, 8'h81, 3, 0);
      drive(1'b0, 1'b1, 8'h03, 1'b1, 8'h55, 7, 0);
    join
    exp_q.push_back(ent(1'b0, 1'b1, 8'h02, 8'h81));
    drive(1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 3, 0);
    exp_q.push_back(ent(1'b1, 1'b1, 8'h03, 8'h55));
    drive(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 3, 0);

    // fairness: both held for four accesses, grants alternate 0,1,0,1
    exp_q.push_back(ent(1'b0, 1'b1, 8'h02, 8'h81));
    exp_q.push_back(ent(1'b1, 1'b1, 8'h03, 8'h55));
    exp_q.push_back(ent(1'b0, 1'b1, 8'h02, 8'h81));
    exp_q.push_back(ent(1'b1, 1'b1, 8'h03, 8'h55));
    fork
      begin
        drive(1'b0, 1'b0, 8'h02, 1'b0, 8'h00, 3, 0);
        drive(1'b0, 1'b0, 8'h02, 1'b0, 8'h00, -1, 0);
      end
      begin
        drive(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, 7, 0);
        drive(1'b0, 1'b1, 8'h03, 1'b0, 8'h00, -1, 0);
      end
    join

    // address changed after the grant must not affect the write
    exp_q.push_back(ent(1'b0, 1'b0, 8'h10, 8'h33));
    drive(1'b0, 1'b0, 8'h10, 1'b1, 8'h33, 3, 1);
    exp_q.push_back(ent(1'b0, 1'b1, 8'h10, 8'h33));
    drive(1'b0, 1'b0, 8'h10, 1'b0, 8'h00, 3, 0);
    exp_q.push_back(ent(1'b0, 1'b1, 8'h7F, 8'h00));
    drive(1'b0, 1'b0, 8'h7F, 1'b0, 8'h00, 3, 0);

    // late request during port 0 strobe waits for the next IDLE
    exp_q.push_back(ent(1'b0, 1'b0, 8'h20, 8'h44));
    exp_q.push_back(ent(1'b1, 1'b1, 8'h20, 8'h44));
    fork
      drive(1'b0, 1'b0, 8'h20, 1'b1, 8'h44, 3, 0);
      begin
        repeat (2) @(negedge clk);
        drive(1'b0, 1'b1, 8'h20, 1'b0, 8'h00, 5, 0);
      end
    join

    // reset during a port 1 write strobe, then re-served
    exp_q.push_back(ent(1'b1, 1'b0, 8'h30, 8'h66));
    fork
      drive(1'b0, 1'b1, 8'h30, 1'b1, 8'h66, -1, 0);
      begin
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_enable", 32'(ram_enable_a), 32'h0);
        check("abort_ram_data", 32'(ram_data_a), 32'hFF);
        check("abort_ack", 32'({bus_a.ack0, bus_a.ack1}), 32'h0);
        check("abort_busy", 32'(bus_a.busy), 32'h0);
        check("abort_ram_addr", 32'(ram_addr_a), 32'h0);
        rst_n = 1'b1;
      end
    join
    exp_q.push_back(ent(1'b0, 1'b1, 8'h30, 8'h66));
    drive(1'b0, 1'b0, 8'h30, 1'b0, 8'h00, 3, 0);

    repeat (3) @(negedge clk);
    check("queue_a_drained", 32'(exp_q.size()), 32'h0);
    check("queue_b_drained", 32'(exp_qb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
